// File: rtl/chunk_serializer.sv
// Word-to-chunk serializer: splits each Nin-bit input word into D Nout-bit chunks.
// Double-buffered (active word A + pending word P) so words stream without bubbles.
module chunk_serializer #(
    parameter int Nin       = 13,
    parameter int Nout      = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_v,
    output logic            in_a,
    input  logic [Nin-1:0]  in_d,
    output logic            out_v,
    input  logic            out_a,
    output logic [Nout-1:0] out_d
);

    localparam int D  = (Nin + Nout - 1) / Nout;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int WW = D * Nout;
    localparam logic [IW-1:0] LAST_IDX = IW'(D - 1);

    logic [Nin-1:0] a_r;
    logic [Nin-1:0] p_r;
    logic           a_full_r;
    logic           p_full_r;
    logic [IW-1:0]  idx_r;

    logic [Nin-1:0] a_nxt_s;
    logic [Nin-1:0] p_nxt_s;
    logic           a_full_nxt_s;
    logic           p_full_nxt_s;
    logic [IW-1:0]  idx_nxt_s;
    logic           accept_s;
    logic           ack_s;
    logic           last_s;

    // Zero-extend the word and pick the chunk addressed by idx in the configured order.
    function automatic logic [Nout-1:0] pick_chunk(input logic [Nin-1:0] word,
                                                   input logic [IW-1:0]  idx);
        logic [WW-1:0] ext;
        logic [IW-1:0] sel;
        ext           = '0;
        ext[Nin-1:0]  = word;
        if (MSB_FIRST) begin
            sel = LAST_IDX - idx;
        end else begin
            sel = idx;
        end
        return ext[sel*Nout +: Nout];
    endfunction

    // Acceptance depends only on pending-slot occupancy, never on out_a.
    assign in_a     = in_v & ~p_full_r & ~reset;
    assign accept_s = in_v & in_a;
    assign ack_s    = a_full_r & out_a;
    assign last_s   = (idx_r == LAST_IDX);

    assign out_v = a_full_r;
    assign out_d = a_full_r ? pick_chunk(a_r, idx_r) : {Nout{1'b0}};

    // Next-state: chunk advance / word retire, then input placement into A or P.
    always_comb begin
        a_nxt_s      = a_r;
        p_nxt_s      = p_r;
        a_full_nxt_s = a_full_r;
        p_full_nxt_s = p_full_r;
        idx_nxt_s    = idx_r;

        if (ack_s) begin
            if (!last_s) begin
                idx_nxt_s = idx_r + 1'b1;
            end else if (p_full_r) begin
                a_nxt_s      = p_r;
                p_full_nxt_s = 1'b0;
                idx_nxt_s    = '0;
            end else begin
                a_full_nxt_s = 1'b0;
                idx_nxt_s    = '0;
            end
        end else begin
            idx_nxt_s = idx_r;
        end

        // A retiring its last chunk this cycle with P empty takes the new word directly.
        if (accept_s) begin
            if (!a_full_r || (ack_s && last_s)) begin
                a_nxt_s      = in_d;
                a_full_nxt_s = 1'b1;
                idx_nxt_s    = '0;
            end else begin
                p_nxt_s      = in_d;
                p_full_nxt_s = 1'b1;
            end
        end else begin
            p_nxt_s = p_nxt_s;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r      <= '0;
            p_r      <= '0;
            a_full_r <= 1'b0;
            p_full_r <= 1'b0;
            idx_r    <= '0;
        end else begin
            a_r      <= a_nxt_s;
            p_r      <= p_nxt_s;
            a_full_r <= a_full_nxt_s;
            p_full_r <= p_full_nxt_s;
            idx_r    <= idx_nxt_s;
        end
    end

endmodule

// File: tb/tb_chunk_serializer.sv
// Self-checking bench for chunk_serializer: three configurations (13/4 LSB-first,
// 13/4 MSB-first, 4/8 single-chunk) driven by directed steps with a chunk scoreboard.
module tb_chunk_serializer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        iv0, ia0, ov0, oa0;
    logic [12:0] id0;
    logic [3:0]  od0;
    logic        iv1, ia1, ov1, oa1;
    logic [12:0] id1;
    logic [3:0]  od1;
    logic        iv2, ia2, ov2, oa2;
    logic [3:0]  id2;
    logic [7:0]  od2;

    chunk_serializer #(.Nin(13), .Nout(4), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .in_v(iv0), .in_a(ia0), .in_d(id0),
        .out_v(ov0), .out_a(oa0), .out_d(od0));
    chunk_serializer #(.Nin(13), .Nout(4), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in_v(iv1), .in_a(ia1), .in_d(id1),
        .out_v(ov1), .out_a(oa1), .out_d(od1));
    chunk_serializer #(.Nin(4), .Nout(8), .MSB_FIRST(1'b0)) dut2 (
        .clk(clk), .reset(reset), .in_v(iv2), .in_a(ia2), .in_d(id2),
        .out_v(ov2), .out_a(oa2), .out_d(od2));

    int total = 0;
    int bad   = 0;
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [7:0] q2[$];
    logic acc0, acc1, acc2;

    logic [3:0]  t1_exp[4]   = '{4'hC, 4'hB, 4'hA, 4'h1};
    logic [3:0]  t2_exp[4]   = '{4'h1, 4'hA, 4'hB, 4'hC};
    logic [12:0] t3_words[3] = '{13'h0123, 13'h1FFF, 13'h0000};
    logic        t3_ia[6]    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0]  t5_in[3]    = '{4'h5, 4'hA, 4'hF};
    logic [7:0]  t5_exp[3]   = '{8'h05, 8'h0A, 8'h0F};
    logic [3:0]  t6_exp[4]   = '{4'h2, 4'h4, 4'h0, 4'h0};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected chunk streams: LSB chunk first for dut0, MSB chunk first for dut1.
    task automatic push0(input logic [12:0] w);
        logic [15:0] e;
        e = {3'b000, w};
        for (int k = 0; k < 4; k++) q0.push_back(e[4*k +: 4]);
    endtask

    task automatic push1(input logic [12:0] w);
        logic [15:0] e;
        e = {3'b000, w};
        for (int k = 3; k >= 0; k--) q1.push_back(e[4*k +: 4]);
    endtask

    // One clock: sample handshakes before the edge, score outputs, queue accepted words.
    task automatic cyc();
        logic [7:0] e;
        #1;
        acc0 = iv0 & ia0;
        acc1 = iv1 & ia1;
        acc2 = iv2 & ia2;
        if (ov0 && oa0) begin
            chk("sb0_pending", 16'(q0.size() != 0), 16'd1);
            if (q0.size() != 0) begin e = 8'(q0.pop_front()); chk("dut0_chunk", 16'(od0), 16'(e)); end
        end
        if (ov1 && oa1) begin
            chk("sb1_pending", 16'(q1.size() != 0), 16'd1);
            if (q1.size() != 0) begin e = 8'(q1.pop_front()); chk("dut1_chunk", 16'(od1), 16'(e)); end
        end
        if (ov2 && oa2) begin
            chk("sb2_pending", 16'(q2.size() != 0), 16'd1);
            if (q2.size() != 0) begin e = q2.pop_front(); chk("dut2_chunk", 16'(od2), 16'(e)); end
        end
        if (acc0) push0(id0);
        if (acc1) push1(id1);
        if (acc2) q2.push_back({4'h0, id2});
        @(negedge clk);
    endtask

    initial begin
        int  wi;
        bit  w3_done;
        reset = 1'b1;
        iv0 = 1'b1; id0 = 13'h1ABC; oa0 = 1'b1;
        iv1 = 1'b1; id1 = 13'h1ABC; oa1 = 1'b1;
        iv2 = 1'b1; id2 = 4'h5;     oa2 = 1'b1;
        #2;
        chk("rst_out_v0", ov0, 1'b0); chk("rst_out_d0", od0, 4'h0); chk("rst_in_a0", ia0, 1'b0);
        chk("rst_out_v1", ov1, 1'b0); chk("rst_in_a1", ia1, 1'b0);
        chk("rst_out_v2", ov2, 1'b0); chk("rst_out_d2", od2, 8'h00); chk("rst_in_a2", ia2, 1'b0);
        @(negedge clk);
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Single word, LSB chunk first
        iv0 = 1'b1; id0 = 13'h1ABC; #1;
        chk("t1_in_a", ia0, 1'b1);
        cyc();
        iv0 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("t1_out_v", ov0, 1'b1); chk("t1_out_d", od0, t1_exp[c]);
            cyc();
        end
        chk("t1_idle_v", ov0, 1'b0); chk("t1_idle_d", od0, 4'h0);

        // Same word, MSB chunk first
        iv1 = 1'b1; id1 = 13'h1ABC;
        cyc();
        iv1 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("t2_out_v", ov1, 1'b1); chk("t2_out_d", od1, t2_exp[c]);
            cyc();
        end
        chk("t2_idle_v", ov1, 1'b0);

        // Back-to-back stream: no gaps, in_a low while P full
        wi = 0;
        for (int c = 0; c < 16; c++) begin
            iv0 = (wi < 3);
            id0 = (wi < 3) ? t3_words[wi] : 13'h0000;
            #1;
            if (c < 6) chk("t3_in_a", ia0, t3_ia[c]);
            if (c >= 1 && c <= 12) chk("t3_no_gap", ov0, 1'b1);
            cyc();
            if (acc0) wi++;
        end
        chk("t3_words_in", 16'(wi), 16'd3);
        chk("t3_drained", 16'(q0.size()), 16'd0);
        chk("t3_idle_v", ov0, 1'b0);

        // Backpressure after chunk 1: output held, P fills, third word refused
        iv0 = 1'b1; id0 = 13'h1234; oa0 = 1'b1;
        cyc();
        id0 = 13'h0567; #1;
        chk("t4_p_accept", ia0, 1'b1);
        cyc();
        id0 = 13'h1111; #1;
        chk("t4_p_full", ia0, 1'b0);
        cyc();
        oa0 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("t4_hold_v", ov0, 1'b1); chk("t4_hold_d", od0, 4'h2); chk("t4_refuse", ia0, 1'b0);
            cyc();
        end
        oa0 = 1'b1;
        w3_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            iv0 = ~w3_done;
            cyc();
            if (acc0) w3_done = 1'b1;
        end
        iv0 = 1'b0;
        chk("t4_third_taken", w3_done, 1'b1);
        chk("t4_drained", 16'(q0.size()), 16'd0);
        chk("t4_idle_v", ov0, 1'b0);

        // Single-chunk words stream one per cycle
        for (int c = 0; c < 5; c++) begin
            iv2 = (c < 3);
            id2 = (c < 3) ? t5_in[c] : 4'h0;
            #1;
            if (c < 3) chk("t5_in_a", ia2, 1'b1);
            if (c >= 1 && c <= 3) begin
                chk("t5_out_v", ov2, 1'b1); chk("t5_out_d", od2, t5_exp[c-1]);
            end
            cyc();
        end
        chk("t5_idle_v", ov2, 1'b0);
        chk("t5_drained", 16'(q2.size()), 16'd0);

        // Reset mid-word with P occupied: everything discarded
        iv0 = 1'b1; id0 = 13'h1ABC;
        cyc();
        id0 = 13'h0777; #1;
        chk("t6_p_accept", ia0, 1'b1);
        cyc();
        iv0 = 1'b0; #1;
        chk("t6_chunk1", od0, 4'hB);
        cyc();
        reset = 1'b1; #1;
        chk("t6_rst_v", ov0, 1'b0); chk("t6_rst_d", od0, 4'h0);
        iv0 = 1'b1; #1;
        chk("t6_rst_in_a", ia0, 1'b0);
        iv0 = 1'b0;
        q0.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        iv0 = 1'b1; id0 = 13'h0042;
        cyc();
        iv0 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c < 4) begin
                chk("t6_out_v", ov0, 1'b1); chk("t6_out_d", od0, t6_exp[c]);
            end
            cyc();
        end
        chk("t6_idle_v", ov0, 1'b0);
        chk("t6_drained", 16'(q0.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
